// File: rtl/hilo_unit.sv
// hilo_unit: multi-cycle multiply/divide unit that owns the HI/LO register pair.
// An accepted operation keeps busy high for its latency and commits to HI/LO
// on the last busy edge. The unit also takes direct mthi/mtlo writes while
// idle and supports flushing an operation that is in flight.
module hilo_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             load_HI,
   input  logic             load_LO,
   input  logic [WIDTH-1:0] load_value,
   input  logic             flush,
   output logic             busy,
   output logic             stall_req,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam int W2         = 2 * WIDTH;

   localparam logic [CW-1:0]    MULT_CNT = CW'(MULT_CYCLES);
   localparam logic [CW-1:0]    DIV_CNT  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] rs_q, rs_d;
   logic [WIDTH-1:0] rt_q, rt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   // Datapath signals derived from the latched operands
   logic [W2-1:0]    acc, rs_ext, rt_ext, prod, result;
   logic             rs_neg, rt_neg, is_div, commit_en;
   logic [WIDTH-1:0] rs_mag, rt_mag, den, quo_mag, rem_mag, quo, rem;

   assign busy      = (state_q == RUN);
   assign stall_req = start | busy;
   assign HI        = hi_q;
   assign LO        = lo_q;

   // Result computation: op[0] selects unsigned, op[2] accumulate, op[1] div or subtract
   always_comb begin
      acc    = {hi_q, lo_q};
      rs_ext = op_q[0] ? {{WIDTH{1'b0}}, rs_q} : {{WIDTH{rs_q[WIDTH-1]}}, rs_q};
      rt_ext = op_q[0] ? {{WIDTH{1'b0}}, rt_q} : {{WIDTH{rt_q[WIDTH-1]}}, rt_q};
      // Low 2*WIDTH bits of the extended product are the exact signed/unsigned product
      prod   = rs_ext * rt_ext;

      is_div  = (op_q[2:1] == 2'b01);
      rs_neg  = ~op_q[0] & rs_q[WIDTH-1];
      rt_neg  = ~op_q[0] & rt_q[WIDTH-1];
      rs_mag  = rs_neg ? -rs_q : rs_q;
      rt_mag  = rt_neg ? -rt_q : rt_q;
      // Divide-by-zero never commits; substitute 1 to keep the divider defined
      den     = (rt_q == '0) ? W_ONE : rt_mag;
      quo_mag = rs_mag / den;
      rem_mag = rs_mag % den;
      // Most-negative / -1 wraps back to itself, which is the required quotient
      quo     = (rs_neg ^ rt_neg) ? -quo_mag : quo_mag;
      rem     = rs_neg ? -rem_mag : rem_mag;

      commit_en = ~(is_div & (rt_q == '0));

      case (op_q)
         3'd2, 3'd3: result = {rem, quo};
         3'd4, 3'd5: result = acc + prod;
         3'd6, 3'd7: result = acc - prod;
         default:    result = prod;
      endcase
   end

   // Next-state logic: accept/run/commit/flush and idle-time mthi/mtlo writes
   always_comb begin
      logic accept;
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      accept  = 1'b0;

      case (state_q)
         IDLE: begin
            if (!flush) begin
               if (start) begin
                  accept = 1'b1;
               end else begin
                  if (load_HI) hi_d = load_value;
                  if (load_LO) lo_d = load_value;
               end
            end
         end
         RUN: begin
            if (flush) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_ONE) begin
               if (commit_en) begin
                  hi_d = result[W2-1:WIDTH];
                  lo_d = result[WIDTH-1:0];
               end
               state_d = IDLE;
               cnt_d   = '0;
               // The commit edge may already take the next operation
               accept  = start;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (accept) begin
         state_d = RUN;
         op_d    = op;
         rs_d    = rs_val;
         rt_d    = rt_val;
         cnt_d   = (op[2:1] == 2'b01) ? DIV_CNT : MULT_CNT;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed tests for hilo_unit with hand-computed expectations.
module tb_hilo_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val, rt_val, load_value;
   logic        load_HI, load_LO, flush;
   logic        busy, stall_req;
   logic [31:0] HI, LO;

   int tests  = 0;
   int errors = 0;

   hilo_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val),
      .load_HI(load_HI), .load_LO(load_LO), .load_value(load_value),
      .flush(flush), .busy(busy), .stall_req(stall_req), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   // Issue one operation and count the negedges on which busy is high afterwards
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int bc);
      @(negedge clk);
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(negedge clk);
      start = 1'b0;
      bc = 0;
      while (busy && bc < 50) begin
         bc++;
         @(negedge clk);
      end
   endtask

   // Idle-time mthi/mtlo write
   task automatic do_load(input logic h, input logic l, input logic [31:0] v);
      @(negedge clk);
      load_HI = h; load_LO = l; load_value = v;
      @(negedge clk);
      load_HI = 1'b0; load_LO = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      tests++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want %h", HI, 32'h0); end
      tests++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want %h", LO, 32'h0); end
      tests++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_req); end
      @(negedge clk); reset = 1'b1;
      $display("[TB] reset released HI=%h LO=%h", HI, LO);
   endtask

   task automatic test_mult();
      int bc;
      do_op(3'd0, 32'hFFFFFFFD, 32'd7, bc);
      $display("[TB] mult -3*7 busy=%0d HI=%h LO=%h", bc, HI, LO);
      tests++; if (bc !== 5) begin errors++; $display("FAIL mult_busy got %0d want 5", bc); end
      tests++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want FFFFFFFF", HI); end
      tests++; if (LO !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got %h want FFFFFFEB", LO); end
      do_op(3'd1, 32'hFFFFFFFD, 32'd7, bc);
      $display("[TB] multu 0xFFFFFFFD*7 busy=%0d HI=%h LO=%h", bc, HI, LO);
      tests++; if (HI !== 32'h00000006) begin errors++; $display("FAIL multu_hi got %h want 00000006", HI); end
      tests++; if (LO !== 32'hFFFFFFEB) begin errors++; $display("FAIL multu_lo got %h want FFFFFFEB", LO); end
   endtask

   task automatic test_div();
      int bc;
      do_op(3'd3, 32'd100, 32'd7, bc);
      $display("[TB] divu 100/7 busy=%0d HI=%h LO=%h", bc, HI, LO);
      tests++; if (bc !== 10) begin errors++; $display("FAIL divu_busy got %0d want 10", bc); end
      tests++; if (LO !== 32'd14) begin errors++; $display("FAIL divu_lo got %h want %h", LO, 32'd14); end
      tests++; if (HI !== 32'd2) begin errors++; $display("FAIL divu_hi got %h want %h", HI, 32'd2); end
      do_op(3'd2, 32'hFFFFFFF9, 32'd2, bc);
      $display("[TB] div -7/2 busy=%0d HI=%h LO=%h", bc, HI, LO);
      tests++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo got %h want FFFFFFFD", LO); end
      tests++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi got %h want FFFFFFFF", HI); end
      do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, bc);
      $display("[TB] div min/-1 busy=%0d HI=%h LO=%h", bc, HI, LO);
      tests++; if (LO !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", LO); end
      tests++; if (HI !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want 00000000", HI); end
   endtask

   task automatic test_div_zero();
      int bc;
      do_load(1'b1, 1'b0, 32'h11);
      do_load(1'b0, 1'b1, 32'h22);
      $display("[TB] preload HI=%h LO=%h", HI, LO);
      tests++; if (HI !== 32'h11 || LO !== 32'h22) begin errors++; $display("FAIL load_hilo got %h/%h want 00000011/00000022", HI, LO); end
      do_op(3'd2, 32'd5, 32'd0, bc);
      $display("[TB] div 5/0 busy=%0d HI=%h LO=%h", bc, HI, LO);
      tests++; if (bc !== 10) begin errors++; $display("FAIL divz_busy got %0d want 10", bc); end
      tests++; if (HI !== 32'h11) begin errors++; $display("FAIL divz_hi got %h want 00000011", HI); end
      tests++; if (LO !== 32'h22) begin errors++; $display("FAIL divz_lo got %h want 00000022", LO); end
   endtask

   task automatic test_accum();
      int bc;
      do_load(1'b1, 1'b0, 32'h0);
      do_load(1'b0, 1'b1, 32'hFFFFFFFF);
      do_op(3'd5, 32'd1, 32'd1, bc);
      $display("[TB] maddu 1*1 busy=%0d HI=%h LO=%h", bc, HI, LO);
      tests++; if (bc !== 5) begin errors++; $display("FAIL maddu_busy got %0d want 5", bc); end
      tests++; if (HI !== 32'd1 || LO !== 32'd0) begin errors++; $display("FAIL maddu_hilo got %h/%h want 00000001/00000000", HI, LO); end
      do_op(3'd6, 32'd1, 32'd1, bc);
      $display("[TB] msub 1*1 busy=%0d HI=%h LO=%h", bc, HI, LO);
      tests++; if (HI !== 32'd0 || LO !== 32'hFFFFFFFF) begin errors++; $display("FAIL msub_hilo got %h/%h want 00000000/FFFFFFFF", HI, LO); end
   endtask

   task automatic test_ignore();
      int bc;
      do_load(1'b1, 1'b1, 32'h0);
      @(negedge clk);
      start = 1'b1; op = 3'd3; rs_val = 32'd9; rt_val = 32'd2;
      @(negedge clk);                     // busy cycle 1
      start = 1'b0;
      @(negedge clk);                     // busy cycle 2
      start = 1'b1; op = 3'd0; rs_val = 32'd3; rt_val = 32'd3;
      load_LO = 1'b1; load_value = 32'h55;
      #1;
      tests++; if (stall_req !== 1'b1) begin errors++; $display("FAIL busy_stall got %b want 1", stall_req); end
      @(negedge clk);
      start = 1'b0; load_LO = 1'b0;
      bc = 2;
      while (busy && bc < 50) begin
         bc++;
         @(negedge clk);
      end
      $display("[TB] divu 9/2 with ignored start/mtlo busy=%0d HI=%h LO=%h", bc, HI, LO);
      tests++; if (bc !== 10) begin errors++; $display("FAIL ignore_busy got %0d want 10", bc); end
      tests++; if (LO !== 32'd4 || HI !== 32'd1) begin errors++; $display("FAIL ignore_hilo got %h/%h want 00000001/00000004", HI, LO); end
      // start and load_HI together in IDLE: the op wins
      @(negedge clk);
      start = 1'b1; op = 3'd1; rs_val = 32'd2; rt_val = 32'd3;
      load_HI = 1'b1; load_value = 32'h99;
      #1;
      tests++; if (stall_req !== 1'b1) begin errors++; $display("FAIL start_stall got %b want 1", stall_req); end
      @(negedge clk);
      start = 1'b0; load_HI = 1'b0;
      bc = 0;
      while (busy && bc < 50) begin
         bc++;
         @(negedge clk);
      end
      $display("[TB] multu 2*3 with mthi busy=%0d HI=%h LO=%h", bc, HI, LO);
      tests++; if (bc !== 5) begin errors++; $display("FAIL prio_busy got %0d want 5", bc); end
      tests++; if (HI !== 32'd0 || LO !== 32'd6) begin errors++; $display("FAIL prio_hilo got %h/%h want 00000000/00000006", HI, LO); end
   endtask

   task automatic test_back_to_back();
      int bc;
      @(negedge clk);
      start = 1'b1; op = 3'd0; rs_val = 32'd2; rt_val = 32'd3;
      @(negedge clk);                     // busy cycle 1
      start = 1'b0;
      repeat (3) @(negedge clk);          // busy cycles 2..4
      @(negedge clk);                     // busy cycle 5: present madd for the commit edge
      start = 1'b1; op = 3'd4; rs_val = 32'd1; rt_val = 32'd1;
      @(negedge clk);
      start = 1'b0;
      $display("[TB] back-to-back after mult busy=%b HI=%h LO=%h", busy, HI, LO);
      tests++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
      tests++; if (HI !== 32'd0 || LO !== 32'd6) begin errors++; $display("FAIL b2b_first got %h/%h want 00000000/00000006", HI, LO); end
      bc = 0;
      while (busy && bc < 50) begin
         bc++;
         @(negedge clk);
      end
      $display("[TB] back-to-back madd busy=%0d HI=%h LO=%h", bc, HI, LO);
      tests++; if (bc !== 5) begin errors++; $display("FAIL b2b_busy2 got %0d want 5", bc); end
      tests++; if (HI !== 32'd0 || LO !== 32'd7) begin errors++; $display("FAIL b2b_second got %h/%h want 00000000/00000007", HI, LO); end
   endtask

   task automatic test_flush();
      do_load(1'b1, 1'b1, 32'hA5);
      @(negedge clk);
      start = 1'b1; op = 3'd0; rs_val = 32'd5; rt_val = 32'd5;
      @(negedge clk);                     // busy cycle 1
      start = 1'b0;
      @(negedge clk);                     // busy cycle 2
      @(negedge clk);                     // busy cycle 3
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      $display("[TB] flush in busy cycle 3 busy=%b HI=%h LO=%h", busy, HI, LO);
      tests++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
      repeat (6) @(negedge clk);
      tests++; if (HI !== 32'hA5 || LO !== 32'hA5) begin errors++; $display("FAIL flush_hilo got %h/%h want 000000A5/000000A5", HI, LO); end
      // flush in IDLE suppresses start and loads
      start = 1'b1; op = 3'd1; load_HI = 1'b1; load_LO = 1'b1; load_value = 32'h3C; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; load_HI = 1'b0; load_LO = 1'b0; flush = 1'b0;
      $display("[TB] flush in idle busy=%b HI=%h LO=%h", busy, HI, LO);
      tests++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_flush_busy got %b want 0", busy); end
      tests++; if (HI !== 32'hA5 || LO !== 32'hA5) begin errors++; $display("FAIL idle_flush_hilo got %h/%h want 000000A5/000000A5", HI, LO); end
   endtask

   task automatic test_reset_mid();
      do_load(1'b1, 1'b0, 32'h77);
      do_load(1'b0, 1'b1, 32'h88);
      @(negedge clk);
      start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      $display("[TB] async reset mid-div busy=%b HI=%h LO=%h", busy, HI, LO);
      tests++; if (HI !== 32'h0 || LO !== 32'h0) begin errors++; $display("FAIL areset_hilo got %h/%h want 00000000/00000000", HI, LO); end
      tests++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
      tests++; if (stall_req !== 1'b0) begin errors++; $display("FAIL areset_stall0 got %b want 0", stall_req); end
      start = 1'b1;
      #1;
      tests++; if (stall_req !== 1'b1) begin errors++; $display("FAIL areset_stall1 got %b want 1", stall_req); end
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
      load_HI = 1'b0; load_LO = 1'b0; load_value = '0; flush = 1'b0;
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_accum();
      test_ignore();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
